// File: rtl/ysyx_22051013_icache_ctrl.sv
// Direct-mapped, read-only instruction cache controller.
// Owns a 64-entry tag RAM ({valid, tag[22:0]}) and a 64 x 64-bit data RAM, both with
// one-cycle read latency. It serves CPU fetches on a hit, refills on a miss through a
// single-beat memory read, and invalidates every entry on reset and on flush_req_i.
//
// Ports:
//   clk_i, rst_i                     clock, synchronous active-high reset
//   cpu_req_valid_i/ready_o/addr_i   fetch request handshake
//   cpu_resp_valid_o/data_o          one-cycle response pulse, data zero when idle
//   flush_req_i, flush_busy_o        invalidate-all request / flush in progress
//   tag_addr_o/wdata_o/wena_o        tag RAM write side and shared index
//   tag_rdata_i, tag_rvalid_i        tag RAM read data (stored tag, valid)
//   data_addr_o/wdata_o/wena_o       data RAM write side, index always equals tag_addr_o
//   data_rdata_i                     data RAM read data
//   mem_req_valid_o/ready_i/addr_o   memory read request
//   mem_resp_valid_i/data_i          memory read response (single beat)
module ysyx_22051013_icache_ctrl (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        cpu_req_valid_i,
   input  logic [31:0] cpu_req_addr_i,
   output logic        cpu_req_ready_o,
   output logic        cpu_resp_valid_o,
   output logic [63:0] cpu_resp_data_o,
   input  logic        flush_req_i,
   output logic        flush_busy_o,
   output logic [5:0]  tag_addr_o,
   output logic [23:0] tag_wdata_o,
   output logic        tag_wena_o,
   input  logic [22:0] tag_rdata_i,
   input  logic        tag_rvalid_i,
   output logic [5:0]  data_addr_o,
   output logic [63:0] data_wdata_o,
   output logic        data_wena_o,
   input  logic [63:0] data_rdata_i,
   output logic        mem_req_valid_o,
   output logic [31:0] mem_req_addr_o,
   input  logic        mem_req_ready_i,
   input  logic        mem_resp_valid_i,
   input  logic [63:0] mem_resp_data_i
);

   typedef enum logic [2:0] {
      StFlush,
      StIdle,
      StLookup,
      StMissReq,
      StMissWait
   } state_e;

   state_e      state_q, state_d;
   logic [22:0] req_tag_q, req_tag_d;
   logic [5:0]  req_idx_q, req_idx_d;
   logic [5:0]  flush_cnt_q, flush_cnt_d;
   logic        flush_pend_q, flush_pend_d;
   logic        hit;

   assign hit = tag_rvalid_i && (tag_rdata_i == req_tag_q);

   // Both RAMs are always addressed with the same index, so a tag write and a data
   // write can never land on different entries.
   assign data_addr_o = tag_addr_o;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q      <= StFlush;
         req_tag_q    <= '0;
         req_idx_q    <= '0;
         flush_cnt_q  <= '0;
         flush_pend_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         req_tag_q    <= req_tag_d;
         req_idx_q    <= req_idx_d;
         flush_cnt_q  <= flush_cnt_d;
         flush_pend_q <= flush_pend_d;
      end
   end

   always_comb begin
      state_d          = state_q;
      req_tag_d        = req_tag_q;
      req_idx_d        = req_idx_q;
      flush_cnt_d      = flush_cnt_q;
      flush_pend_d     = flush_pend_q;
      cpu_req_ready_o  = 1'b0;
      cpu_resp_valid_o = 1'b0;
      cpu_resp_data_o  = '0;
      flush_busy_o     = 1'b0;
      tag_addr_o       = req_idx_q;
      tag_wdata_o      = '0;
      tag_wena_o       = 1'b0;
      data_wdata_o     = '0;
      data_wena_o      = 1'b0;
      mem_req_valid_o  = 1'b0;
      mem_req_addr_o   = '0;

      unique case (state_q)
         StFlush: begin
            flush_busy_o = 1'b1;
            tag_wena_o   = 1'b1;
            tag_addr_o   = flush_cnt_q;
            flush_cnt_d  = flush_cnt_q + 6'd1;
            if (flush_cnt_q == 6'd63) begin
               state_d      = StIdle;
               flush_cnt_d  = '0;
               flush_pend_d = 1'b0;
            end
         end

         StIdle: begin
            // Speculative read so tag and data are ready in LOOKUP.
            tag_addr_o = cpu_req_addr_i[8:3];
            if (flush_req_i || flush_pend_q) begin
               state_d = StFlush;
            end else begin
               cpu_req_ready_o = 1'b1;
               if (cpu_req_valid_i) begin
                  req_tag_d = cpu_req_addr_i[31:9];
                  req_idx_d = cpu_req_addr_i[8:3];
                  state_d   = StLookup;
               end
            end
         end

         StLookup: begin
            if (flush_req_i) flush_pend_d = 1'b1;
            if (hit) begin
               cpu_resp_valid_o = 1'b1;
               cpu_resp_data_o  = data_rdata_i;
               state_d          = StIdle;
            end else begin
               state_d = StMissReq;
            end
         end

         StMissReq: begin
            if (flush_req_i) flush_pend_d = 1'b1;
            mem_req_valid_o = 1'b1;
            mem_req_addr_o  = {req_tag_q, req_idx_q, 3'b000};
            if (mem_req_ready_i) state_d = StMissWait;
         end

         StMissWait: begin
            if (flush_req_i) flush_pend_d = 1'b1;
            if (mem_resp_valid_i) begin
               tag_wena_o       = 1'b1;
               tag_wdata_o      = {1'b1, req_tag_q};
               data_wena_o      = 1'b1;
               data_wdata_o     = mem_resp_data_i;
               cpu_resp_valid_o = 1'b1;
               cpu_resp_data_o  = mem_resp_data_i;
               state_d          = StIdle;
            end
         end

         default: begin
            state_d = StFlush;
         end
      endcase
   end

endmodule

// File: tb/tb_ysyx_22051013_icache_ctrl.sv
// Directed bench for ysyx_22051013_icache_ctrl with behavioural tag/data RAMs
// (one-cycle read latency) and a hand-driven memory port.
module tb_ysyx_22051013_icache_ctrl;

   logic        clk;
   logic        rst;
   logic        cpu_req_valid;
   logic [31:0] cpu_req_addr;
   logic        cpu_req_ready;
   logic        cpu_resp_valid;
   logic [63:0] cpu_resp_data;
   logic        flush_req;
   logic        flush_busy;
   logic [5:0]  tag_addr;
   logic [23:0] tag_wdata;
   logic        tag_wena;
   logic [22:0] tag_rdata;
   logic        tag_rvalid;
   logic [5:0]  data_addr;
   logic [63:0] data_wdata;
   logic        data_wena;
   logic [63:0] data_rdata;
   logic        mem_req_valid;
   logic [31:0] mem_req_addr;
   logic        mem_req_ready;
   logic        mem_resp_valid;
   logic [63:0] mem_resp_data;

   int n_cmp = 0;
   int n_err = 0;

   ysyx_22051013_icache_ctrl dut (
      .clk_i            (clk),
      .rst_i            (rst),
      .cpu_req_valid_i  (cpu_req_valid),
      .cpu_req_addr_i   (cpu_req_addr),
      .cpu_req_ready_o  (cpu_req_ready),
      .cpu_resp_valid_o (cpu_resp_valid),
      .cpu_resp_data_o  (cpu_resp_data),
      .flush_req_i      (flush_req),
      .flush_busy_o     (flush_busy),
      .tag_addr_o       (tag_addr),
      .tag_wdata_o      (tag_wdata),
      .tag_wena_o       (tag_wena),
      .tag_rdata_i      (tag_rdata),
      .tag_rvalid_i     (tag_rvalid),
      .data_addr_o      (data_addr),
      .data_wdata_o     (data_wdata),
      .data_wena_o      (data_wena),
      .data_rdata_i     (data_rdata),
      .mem_req_valid_o  (mem_req_valid),
      .mem_req_addr_o   (mem_req_addr),
      .mem_req_ready_i  (mem_req_ready),
      .mem_resp_valid_i (mem_resp_valid),
      .mem_resp_data_i  (mem_resp_data)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // RAM models. Preload fills every entry with a valid tag that would alias the
   // first test address, so a missing flush shows up as a false hit.
   logic        ram_init;
   logic [23:0] tag_mem [64];
   logic [63:0] data_mem [64];
   logic [23:0] tag_rd_q;
   logic [63:0] data_rd_q;

   always @(posedge clk) begin
      if (ram_init) begin
         for (int i = 0; i < 64; i++) begin
            tag_mem[i]  <= {1'b1, 23'h400000};
            data_mem[i] <= 64'hDEAD_0000_0000_0000 | 64'(i);
         end
      end else begin
         if (tag_wena)  tag_mem[tag_addr]   <= tag_wdata;
         if (data_wena) data_mem[data_addr] <= data_wdata;
      end
      tag_rd_q  <= tag_mem[tag_addr];
      data_rd_q <= data_mem[data_addr];
   end

   assign tag_rdata  = tag_rd_q[22:0];
   assign tag_rvalid = tag_rd_q[23];
   assign data_rdata = data_rd_q;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string name, input logic [191:0] obs, input logic [191:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
      end
   endtask

   // Entered in the first FLUSH cycle; returns in the first IDLE cycle.
   task automatic run_flush(input string name);
      for (int i = 0; i < 64; i++) begin
         #2;
         check({name, "_walk"},
               {flush_busy, tag_wena, tag_addr, tag_wdata, cpu_req_ready, data_wena},
               {1'b1, 1'b1, 6'(i), 24'h0, 1'b0, 1'b0});
         tick();
      end
      #2;
      check({name, "_done"}, {cpu_req_ready, flush_busy, tag_wena}, 3'b100);
   endtask

   // Entered in IDLE; returns in IDLE after the refill.
   task automatic miss(input string name, input logic [31:0] a, input logic [63:0] d,
                       input int stall, input bit fl);
      cpu_req_valid = 1'b1;
      cpu_req_addr  = a;
      #2;
      check({name, "_acc"}, {cpu_req_ready, tag_addr, data_addr}, {1'b1, a[8:3], a[8:3]});
      tick();
      cpu_req_valid = 1'b0;
      cpu_req_addr  = '0;
      #2;
      check({name, "_lookup"}, {cpu_resp_valid, cpu_resp_data, mem_req_valid}, '0);
      tick();
      for (int k = 0; k <= stall; k++) begin
         mem_req_ready = (k == stall);
         #2;
         check({name, "_req"}, {mem_req_valid, mem_req_addr}, {1'b1, a[31:3], 3'b000});
         tick();
      end
      mem_req_ready = 1'b0;
      if (fl) begin
         flush_req = 1'b1;
         #2;
         check({name, "_wait"},
               {mem_req_valid, cpu_resp_valid, tag_wena, data_wena, cpu_req_ready}, '0);
         tick();
         flush_req = 1'b0;
      end
      mem_resp_valid = 1'b1;
      mem_resp_data  = d;
      #2;
      check({name, "_refill"},
            {tag_wena, tag_addr, tag_wdata, data_wena, data_addr, data_wdata,
             cpu_resp_valid, cpu_resp_data, mem_req_valid},
            {1'b1, a[8:3], 1'b1, a[31:9], 1'b1, a[8:3], d, 1'b1, d, 1'b0});
      tick();
      mem_resp_valid = 1'b0;
      mem_resp_data  = '0;
      #2;
      check({name, "_after"}, {cpu_resp_valid, cpu_resp_data, mem_req_valid}, '0);
   endtask

   // Entered in IDLE; returns in IDLE.
   task automatic hit(input string name, input logic [31:0] a, input logic [63:0] d);
      cpu_req_valid = 1'b1;
      cpu_req_addr  = a;
      #2;
      check({name, "_acc"}, {cpu_req_ready, tag_addr}, {1'b1, a[8:3]});
      tick();
      cpu_req_valid = 1'b0;
      cpu_req_addr  = '0;
      #2;
      check({name, "_resp"}, {cpu_resp_valid, cpu_resp_data, mem_req_valid}, {1'b1, d, 1'b0});
      tick();
   endtask

   initial begin
      rst            = 1'b1;
      ram_init       = 1'b1;
      cpu_req_valid  = 1'b0;
      cpu_req_addr   = '0;
      flush_req      = 1'b0;
      mem_req_ready  = 1'b0;
      mem_resp_valid = 1'b0;
      mem_resp_data  = '0;

      // Reset and full flush.
      tick();
      ram_init = 1'b0;
      #2;
      check("reset_outs",
            {cpu_req_ready, cpu_resp_valid, mem_req_valid, data_wena, flush_busy, tag_wena},
            6'b000011);
      tick();
      rst = 1'b0;
      run_flush("init_flush");

      // Cold miss, hit on same line, conflict with 5-cycle stall, re-miss.
      miss("cold", 32'h8000_0008, 64'h1122_3344_5566_7788, 0, 1'b0);
      tick();
      hit("hit1", 32'h8000_000C, 64'h1122_3344_5566_7788);
      miss("conflict", 32'h8000_0208, 64'hAAAA_BBBB_CCCC_DDDD, 5, 1'b0);
      tick();
      hit("hit2", 32'h8000_0208, 64'hAAAA_BBBB_CCCC_DDDD);
      miss("remiss", 32'h8000_0008, 64'h0102_0304_0506_0708, 0, 1'b0);
      tick();
      miss("idx2", 32'h8000_0010, 64'h0F0E_0D0C_0B0A_0908, 2, 1'b0);
      tick();
      hit("hit3", 32'h8000_0014, 64'h0F0E_0D0C_0B0A_0908);
      hit("hit4", 32'h8000_0008, 64'h0102_0304_0506_0708);

      // flush_req during MISS_WAIT: miss completes, then a full flush.
      miss("flmiss", 32'h8000_0408, 64'h5555_6666_7777_8888, 1, 1'b1);
      check("pend_idle", {cpu_req_ready, flush_busy}, 2'b00);
      tick();
      run_flush("pend_flush");
      miss("post_flush", 32'h8000_0408, 64'h9999_AAAA_BBBB_CCCC, 0, 1'b0);
      tick();

      // flush_req wins over a simultaneous request.
      flush_req     = 1'b1;
      cpu_req_valid = 1'b1;
      cpu_req_addr  = 32'h8000_0408;
      #2;
      check("flush_wins", {cpu_req_ready, flush_busy}, 2'b00);
      tick();
      flush_req     = 1'b0;
      cpu_req_valid = 1'b0;
      cpu_req_addr  = '0;
      run_flush("req_flush");
      miss("post_flush2", 32'h8000_0408, 64'h1234_5678_9ABC_DEF0, 0, 1'b0);
      tick();

      // Reset in the middle of a miss restarts the flush.
      cpu_req_valid = 1'b1;
      cpu_req_addr  = 32'h8000_1008;
      tick();
      cpu_req_valid = 1'b0;
      cpu_req_addr  = '0;
      tick();
      #2;
      check("mid_req", {mem_req_valid, mem_req_addr}, {1'b1, 32'h8000_1008});
      rst = 1'b1;
      tick();
      rst = 1'b0;
      #2;
      check("mid_reset", {mem_req_valid, flush_busy, cpu_resp_valid}, 3'b010);
      run_flush("mid_flush");
      miss("after_rst", 32'h8000_0408, 64'hCAFE_F00D_0000_0001, 0, 1'b0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/ysyx_22051013_icache_ctrl.md
# ysyx_22051013_icache_ctrl

Direct-mapped, read-only cache controller that owns and drives the 64-entry tag RAM and its companion data RAM. It accepts CPU fetch requests and looks up tag and data. On a hit it returns the 64-bit line word. On a miss it fetches the word from memory and refills both RAMs. It also invalidates all 64 entries on reset and on `flush_req` (fence.i). It sits between the IF stage and the memory arbiter.

## Interface
Parameters: none. Geometry is fixed:
- Address is 32 bits.
- tag = addr[31:9] (23 bits), index = addr[8:3] (6 bits), offset = addr[2:0] (ignored).
- Line size is 64 bits.

Ports:
- clk  in  1  system clock; all logic on rising edge
- rst  in  1  synchronous, active-high reset
- cpu_req_valid  in  1  fetch request
- cpu_req_addr  in  32  fetch address
- cpu_req_ready  out  1  request accepted when valid&&ready
- cpu_resp_valid  out  1  one-cycle response pulse; no backpressure
- cpu_resp_data  out  64  line word
- flush_req  in  1  invalidate-all request (level or pulse)
- flush_busy  out  1  flush in progress
- tag_addr  out  6  tag RAM index
- tag_wdata  out  24  {valid, tag[22:0]}
- tag_wena  out  1  tag RAM write enable
- tag_rdata  in  23  stored tag; one-cycle read latency
- tag_rvalid  in  1  stored valid bit; one-cycle read latency
- data_addr  out  6  data RAM index; always equal to tag_addr
- data_wdata  out  64  refill data
- data_wena  out  1  data RAM write enable
- data_rdata  in  64  stored word; one-cycle read latency
- mem_req_valid  out  1  memory read request
- mem_req_addr  out  32  {tag, index, 3'b000}
- mem_req_ready  in  1  memory accepts request
- mem_resp_valid  in  1  read data valid (single beat)
- mem_resp_data  in  64  read data

## Operation
States: FLUSH, IDLE, LOOKUP, MISS_REQ, MISS_WAIT.

Registers:
- req_tag (23 bits) and req_idx (6 bits), latched on accept.
- flush_cnt (6 bits).
- flush_pend (1 bit).

FLUSH
- Entered on reset, and from IDLE when flush_req or flush_pend is set.
- Each cycle drives tag_wena=1, tag_addr=flush_cnt, tag_wdata=24'h0, then increments flush_cnt.
- After writing index 63, goes to IDLE and clears flush_cnt and flush_pend.
- data_wena=0 throughout.

IDLE
- cpu_req_ready=1 only when neither flush_req nor flush_pend is set. flush_req wins over a simultaneous cpu_req_valid.
- tag_addr and data_addr = cpu_req_addr[8:3], so the RAMs read speculatively.
- On accept: latch req_tag and req_idx, then go to LOOKUP.

LOOKUP
- Addresses = req_idx.
- Hit when tag_rvalid && tag_rdata==req_tag:
  - cpu_resp_valid=1, cpu_resp_data=data_rdata.
  - Go to IDLE.
- Otherwise go to MISS_REQ.

MISS_REQ
- mem_req_valid=1, mem_req_addr={req_tag, req_idx, 3'b0}.
- Both outputs are held stable until mem_req_ready. On ready, go to MISS_WAIT.

MISS_WAIT
- Waits for mem_resp_valid. In that cycle:
  - tag_wena=1, tag_wdata={1'b1, req_tag}.
  - data_wena=1, data_wdata=mem_resp_data.
  - cpu_resp_valid=1, cpu_resp_data=mem_resp_data (bypass).
  - Go to IDLE.

Flush and other rules
- flush_req seen in LOOKUP, MISS_REQ or MISS_WAIT sets flush_pend. The current request completes first; the flush then runs from IDLE.
- flush_busy=1 exactly while in FLUSH.
- tag_wena and data_wena are never asserted together with different indices.
- cpu_resp_data is 64'h0 whenever cpu_resp_valid=0.

## Timing
Reset
- rst at a rising edge forces state=FLUSH, flush_cnt=0, flush_pend=0, and clears req_tag and req_idx.
- In the cycle after reset, these outputs are 0: cpu_req_ready, cpu_resp_valid, mem_req_valid, data_wena. flush_busy and tag_wena are 1.
- rst mid-miss abandons the transaction (the memory side shares rst) and restarts the full flush.

Latency
- Full flush takes 64 cycles. The first cpu_req_ready=1 is in cycle 64 after reset release.
- Hit: request accepted in cycle N, cpu_resp_valid in N+1. Back-to-back hits sustain one request per 2 cycles.
- Miss: mem_req_valid rises in N+2. The response occurs in the same cycle as mem_resp_valid. IDLE follows in the next cycle.
- A hit right after a refill to the same index reads the new contents, because the RAM write commits before the IDLE read.

## Test plan
- Reset release: 64 consecutive cycles with tag_wena=1, tag_addr 0..63, tag_wdata=0 and flush_busy=1, then cpu_req_ready=1 in cycle 64.
- Cold miss on 0x8000_0008:
  - mem_req_addr=0x8000_0008 in N+2.
  - Memory returns 0x1122334455667788.
  - Same cycle: tag_addr=1, tag_wdata={1, 23'h400000}, data write, and cpu_resp_data=0x1122334455667788.
- Hit on 0x8000_000C after that miss: cpu_resp_valid in N+1 with 0x1122334455667788, and no mem_req_valid.
- Conflict on 0x8000_0208 (index 1, tag 23'h400001): miss, then refill overwrites index 1. A following access to 0x8000_0008 misses again.
- mem_req_ready held low for 5 cycles: mem_req_valid and mem_req_addr are stable throughout, with a single handshake.
- flush_req pulsed during MISS_WAIT:
  - The miss completes normally.
  - A 64-cycle flush follows, with cpu_req_ready=0 throughout.
  - The next access to 0x8000_0008 misses.
